file_header_detect: RTL and testbench
=====================================

FILE_HEADER_DETECT -- requirements
Module: file_header_detect

Interface
REQ-001 Parameter BUFFER_BASE, default 25'h200000: SDRAM byte address of the download buffer holding the loaded file.
REQ-002 Parameter HDR_LEN, default 16: maximum number of header bytes read and classified.
REQ-003 clk32  in  1  system clock; every register updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse: a file download into the buffer has completed.
REQ-006 file_size  in  32  byte count of the downloaded file, sampled at the accepted start.
REQ-007 rd_req  out  1  SDRAM byte-read request; level signal held until acknowledged.
REQ-008 rd_addr  out  25  SDRAM byte address, stable while rd_req=1.
REQ-009 rd_ack  in  1  one-cycle pulse: rd_data is valid and the request is complete.
REQ-010 rd_data  in  8  read byte, valid only in the rd_ack cycle.
REQ-011 busy  out  1  high from the accepted start until the done cycle, inclusive.
REQ-012 done  out  1  one-cycle pulse: file_type and load_addr are valid.
REQ-013 file_type  out  3  file type: 0 NONE, 1 PRG, 2 T64, 3 CRT, 4 TAP.
REQ-014 load_addr  out  16  PRG load address, {byte1,byte0}; 0 for all other types.

Function
REQ-015 The state machine SHALL use states IDLE, REQ, WAIT, CLASSIFY and DONE.
REQ-016 IDLE: start=1 SHALL latch file_size, compute n=min(file_size,HDR_LEN), clear header bytes to 0x00 and byte index to 0, set busy, and go to REQ; if n=0, go to CLASSIFY instead.
REQ-017 REQ SHALL drive rd_req=1 and rd_addr=BUFFER_BASE+index, then go to WAIT on the next cycle.
REQ-018 WAIT SHALL hold rd_req and rd_addr until rd_ack=1, then store rd_data at header[index] and increment index.
REQ-019 After each stored byte, the block SHALL go to CLASSIFY if index=n, otherwise to REQ; rd_req SHALL drop in the cycle after rd_ack.
REQ-020 rd_ack outside WAIT SHALL be ignored.
REQ-021 Header bytes that are not read (index>=n) SHALL remain 0x00.
REQ-022 CLASSIFY SHALL evaluate rules in priority order, in one cycle:
  - CRT: header[0..15] = "C64 CARTRIDGE" followed by three spaces.
  - TAP: header[0..11] = "C64-TAPE-RAW".
  - T64: header[0..3] = "C64S", or header[0..7] = "C64 tape".
  - PRG: none of the above, and file_size>=3.
  - NONE: otherwise.
REQ-023 Signature matching SHALL be exact and case-sensitive on ASCII bytes.
REQ-024 load_addr SHALL equal {header[1],header[0]} only when the type is PRG.
REQ-025 DONE SHALL pulse done=1 for exactly one cycle with outputs valid, then return to IDLE with busy=0.
REQ-026 file_type and load_addr SHALL hold their values until the next CLASSIFY.
REQ-027 start while busy=1 SHALL be ignored, including start in the DONE cycle.
REQ-028 Latency from accepted start to done SHALL be 2 + sum over n reads of (cycles to rd_ack + 1); for n=0 it SHALL be exactly 2 cycles.
REQ-029 The size comparison SHALL be unsigned 32-bit; file_size >= 2^31 SHALL be treated as large, not negative.

Reset
REQ-030 reset=1 SHALL force IDLE, with rd_req=0, rd_addr=0, busy=0, done=0, file_type=0, load_addr=0, index=0 and header cleared.
REQ-031 Reset mid-transaction SHALL abort it without a done pulse; a rd_ack arriving after reset SHALL be ignored.

Structure
REQ-032 A shared package SHALL hold the file_type codes, the state encoding, and the BUFFER_BASE / 1M buffer address constants used by the downstream transfer logic.
REQ-033 Signature comparison SHALL be a purely combinational sub-module, hdr_sig_match (16 header bytes in, type code out); all sequencing SHALL stay in file_header_detect.

Verification
REQ-034 CRT header "C64 CARTRIDGE   ", file_size=8272, rd_ack 2 cycles after each request -> 16 reads at 0x200000..0x20000F, file_type=3, load_addr=0, done once.
REQ-035 PRG bytes 01 08 0B 08, file_size=100 -> file_type=1, load_addr=0x0801.
REQ-036 file_size=0 -> no rd_req, done exactly 2 cycles after start, file_type=0; file_size=2 -> 2 reads, file_type=0.
REQ-037 TAP header "C64-TAPE-RAW" with file_size=12 -> 12 reads, file_type=4; then "C64S tape file" -> file_type=2.
REQ-038 Reset asserted in WAIT after the 5th read, with a late rd_ack afterwards -> rd_req=0 and busy=0 next cycle, no done; a new start runs a clean 16-read detection.
REQ-039 start pulsed while busy, and rd_ack pulsed while in IDLE -> both ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/file_header_detect_pkg.sv
// Shared types and constants for the download-buffer header detector
// and for the transfer logic that reads the same buffer afterwards.
package file_header_detect_pkg;

    typedef enum logic [2:0] {
        FT_NONE = 3'd0,
        FT_PRG  = 3'd1,
        FT_T64  = 3'd2,
        FT_CRT  = 3'd3,
        FT_TAP  = 3'd4
    } file_type_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT     = 3'd2,
        S_CLASSIFY = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    // Download buffer: 1 MiB window in SDRAM starting at 2 MiB.
    localparam logic [24:0] BUFFER_BASE_DEFAULT = 25'h200000;
    localparam logic [24:0] BUFFER_SIZE         = 25'h100000;
    localparam logic [24:0] BUFFER_LAST         = BUFFER_BASE_DEFAULT + BUFFER_SIZE - 25'd1;

    localparam int unsigned SIG_BYTES = 16;

    // Byte 0 of the file sits at index 0, i.e. in the most significant byte.
    typedef logic [0:SIG_BYTES-1][7:0] header_t;

endpackage

// File: rtl/file_header_detect_sig_match.sv
// Combinational signature matcher: classifies 16 header bytes by their
// magic strings. PRG has no signature and is decided by the caller.
module hdr_sig_match
    import file_header_detect_pkg::*;
(
    input  header_t    header,
    output file_type_e sig_type
);

    localparam logic [127:0] CRT_SIG  = "C64 CARTRIDGE   ";
    localparam logic [95:0]  TAP_SIG  = "C64-TAPE-RAW";
    localparam logic [31:0]  T64_SIG1 = "C64S";
    localparam logic [63:0]  T64_SIG2 = "C64 tape";

    logic [127:0] flat;

    assign flat = header;

    always_comb begin
        sig_type = FT_NONE;
        if (flat == CRT_SIG)
            sig_type = FT_CRT;
        else if (flat[127:32] == TAP_SIG)
            sig_type = FT_TAP;
        else if (flat[127:96] == T64_SIG1 || flat[127:64] == T64_SIG2)
            sig_type = FT_T64;
    end

endmodule

// File: rtl/file_header_detect.sv
// Reads up to HDR_LEN header bytes of a freshly downloaded file from SDRAM
// and reports its type (and the PRG load address) with a one-cycle done pulse.
//
// state    | meaning
// IDLE     | waiting for start
// REQ      | issue byte read at BUFFER_BASE+index
// WAIT     | hold request until rd_ack, store byte
// CLASSIFY | evaluate signatures, register results
// DONE     | done pulse, busy drops on exit
module file_header_detect
    import file_header_detect_pkg::*;
#(
    parameter logic [24:0] BUFFER_BASE = BUFFER_BASE_DEFAULT,
    parameter int unsigned HDR_LEN     = 16
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] file_size,
    output logic        rd_req,
    output logic [24:0] rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic [2:0]  file_type,
    output logic [15:0] load_addr
);

    localparam int unsigned N_MAX = (HDR_LEN > SIG_BYTES) ? SIG_BYTES : HDR_LEN;

    state_e      state;
    header_t     header;
    logic [4:0]  idx;
    logic [4:0]  n_len;
    logic [31:0] size_q;
    logic [4:0]  n_next;
    file_type_e  sig_type;
    file_type_e  cls_type;

    // Unsigned compare, so sizes with bit 31 set count as large.
    assign n_next = (file_size < 32'(N_MAX)) ? file_size[4:0] : 5'(N_MAX);

    hdr_sig_match u_sig (
        .header   (header),
        .sig_type (sig_type)
    );

    always_comb begin
        cls_type = sig_type;
        if (sig_type == FT_NONE && size_q >= 32'd3)
            cls_type = FT_PRG;
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            file_type <= FT_NONE;
            load_addr <= '0;
            idx       <= '0;
            n_len     <= '0;
            size_q    <= '0;
            header    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q <= file_size;
                        n_len  <= n_next;
                        header <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= (n_next == 5'd0) ? S_CLASSIFY : S_REQ;
                    end
                end
                S_REQ: begin
                    rd_req  <= 1'b1;
                    rd_addr <= BUFFER_BASE + 25'(idx);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_ack) begin
                        header[idx[3:0]] <= rd_data;
                        idx              <= idx + 5'd1;
                        rd_req           <= 1'b0;
                        state            <= (idx + 5'd1 == n_len) ? S_CLASSIFY : S_REQ;
                    end
                end
                S_CLASSIFY: begin
                    file_type <= cls_type;
                    load_addr <= (cls_type == FT_PRG) ? {header[1], header[0]} : 16'h0000;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_file_header_detect.sv
// Self-checking bench for file_header_detect: fixed vector table, random
// headers against a string-level reference model, reset/abort sequences.
module tb_file_header_detect;
    import file_header_detect_pkg::*;

    localparam logic [24:0] BASE = 25'h200000;

    logic        clk32 = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] file_size;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic [2:0]  file_type;
    logic [15:0] load_addr;

    always #5 clk32 = ~clk32;

    file_header_detect dut (
        .clk32     (clk32),
        .reset     (reset),
        .start     (start),
        .file_size (file_size),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .file_type (file_type),
        .load_addr (load_addr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SDRAM model: acks ack_delay cycles after rd_req is first seen high.
    logic [0:15][7:0] mem = '0;
    int ack_delay = 0;
    int hold_at   = 1 << 30;
    int acks      = 0;
    int force_req = 0;

    initial begin : bus_model
        int wcnt = 0;
        int force_seen = 0;
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(posedge clk32);
            #1;
            rd_ack = 1'b0;
            if (force_req != force_seen) begin
                force_seen++;
                rd_ack  = 1'b1;
                rd_data = 8'h5A;
            end else if (rd_req && acks < hold_at) begin
                if (wcnt >= ack_delay) begin
                    rd_ack  = 1'b1;
                    rd_data = (rd_addr >= BASE && rd_addr < BASE + 25'd16) ?
                              mem[int'(rd_addr - BASE)] : 8'hEE;
                    acks++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    function automatic logic [0:15][7:0] mk(input string s);
        logic [0:15][7:0] r = '0;
        for (int i = 0; i < s.len() && i < 16; i++) r[i] = s[i];
        return r;
    endfunction

    function automatic bit has_prefix(input logic [0:15][7:0] h, input string s);
        for (int i = 0; i < s.len(); i++)
            if (h[i] != s[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: keep only the bytes the block is allowed to read, then apply the rules.
    function automatic logic [2:0] model_type(input logic [31:0] sz, input logic [0:15][7:0] b);
        logic [0:15][7:0] h = '0;
        int n = (sz > 16) ? 16 : int'(sz);
        for (int i = 0; i < n; i++) h[i] = b[i];
        if (has_prefix(h, "C64 CARTRIDGE   ")) return 3'd3;
        if (has_prefix(h, "C64-TAPE-RAW"))     return 3'd4;
        if (has_prefix(h, "C64S") || has_prefix(h, "C64 tape")) return 3'd2;
        if (sz >= 32'd3) return 3'd1;
        return 3'd0;
    endfunction

    task automatic run_one(input string tag, input logic [31:0] sz, input logic [0:15][7:0] bytes,
                           input int d, input logic [2:0] exp_t, input logic [15:0] exp_l,
                           input bit spam);
        int n, exp_lat, reads, dones, lat;
        bit busy_bad;
        logic [2:0]  got_t;
        logic [15:0] got_l;
        n        = (sz > 16) ? 16 : int'(sz);
        exp_lat  = 2 + n * (d + 2);
        mem      = bytes;
        ack_delay = d;
        reads = 0; dones = 0; lat = -1; busy_bad = 0;
        got_t = 'x; got_l = 'x;
        @(negedge clk32);
        start = 1'b1; file_size = sz;
        @(negedge clk32);
        start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            if (k > 1) @(negedge clk32);
            if (spam && n > 0 && k == 3) begin start = 1'b1; file_size = 32'd0; end
            else if (spam && n > 0 && k == 4) start = 1'b0;
            if (lat < 0 && !busy) busy_bad = 1;
            if (rd_ack && rd_req) begin
                check({tag, " rd_addr"}, 32'(rd_addr), 32'(BASE + 25'(reads)));
                reads++;
            end
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = k; got_t = file_type; got_l = load_addr;
                    if (spam) start = 1'b1;
                end
            end
            if (lat > 0 && k == lat + 1) start = 1'b0;
            if (lat > 0 && k == lat + 4) break;
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(lat > 0), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " reads"}, 32'(reads), 32'(n));
        check({tag, " done_count"}, 32'(dones), 32'd1);
        check({tag, " busy_held"}, 32'(busy_bad), 32'd0);
        check({tag, " file_type"}, 32'(got_t), 32'(exp_t));
        check({tag, " load_addr"}, 32'(got_l), 32'(exp_l));
        check({tag, " idle_after"}, {30'd0, busy, rd_req}, 32'd0);
        check({tag, " type_hold"}, 32'(file_type), 32'(exp_t));
    endtask

    typedef struct {
        logic [31:0]      sz;
        logic [0:15][7:0] b;
        int               d;
        logic [2:0]       t;
        logic [15:0]      la;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int found;
        int dn;
        int bz;
        reset = 1'b1; start = 1'b0; file_size = '0;
        repeat (3) @(negedge clk32);
        check("reset rd_req", 32'(rd_req), 32'd0);
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset busy_done", {30'd0, busy, done}, 32'd0);
        check("reset file_type", 32'(file_type), 32'd0);
        check("reset load_addr", 32'(load_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk32);

        tbl[0]  = '{32'd8272, mk("C64 CARTRIDGE   "), 2, 3'd3, 16'h0000};
        tbl[1]  = '{32'd100, {8'h01, 8'h08, 8'h0B, 8'h08, 96'h0}, 1, 3'd1, 16'h0801};
        tbl[2]  = '{32'd0, mk("C64 CARTRIDGE   "), 1, 3'd0, 16'h0000};
        tbl[3]  = '{32'd2, {8'h01, 8'h08, 112'h0}, 0, 3'd0, 16'h0000};
        tbl[4]  = '{32'd12, mk("C64-TAPE-RAW"), 1, 3'd4, 16'h0000};
        tbl[5]  = '{32'd14, mk("C64S tape file"), 0, 3'd2, 16'h0000};
        tbl[6]  = '{32'd8, mk("C64 tape"), 3, 3'd2, 16'h0000};
        tbl[7]  = '{32'd12, mk("C64 CARTRIDGE   "), 0, 3'd1, 16'h3643};
        tbl[8]  = '{32'd3, {8'hAA, 8'hBB, 8'hCC, 104'h0}, 2, 3'd1, 16'hBBAA};
        tbl[9]  = '{32'h8000_0005, mk("c64 cartridge   "), 1, 3'd1, 16'h3663};
        tbl[10] = '{32'd11, mk("C64-TAPE-RAW"), 0, 3'd1, 16'h3643};
        tbl[11] = '{32'hFFFF_FFFF, mk("C64-TAPE-RAW"), 0, 3'd4, 16'h0000};

        for (int i = 0; i < 12; i++)
            run_one($sformatf("vec%0d", i), tbl[i].sz, tbl[i].b, tbl[i].d, tbl[i].t, tbl[i].la, (i % 2) == 1);

        // rd_ack while idle must not start or disturb anything
        force_req++;
        bz = 0; dn = 0;
        repeat (4) begin
            @(negedge clk32);
            if (busy || rd_req) bz++;
            if (done) dn++;
        end
        check("idle_ack busy", 32'(bz), 32'd0);
        check("idle_ack done", 32'(dn), 32'd0);

        // reset while waiting on the 6th read, then a late ack
        mem = mk("C64 CARTRIDGE   ");
        ack_delay = 1;
        hold_at = acks + 5;
        @(negedge clk32);
        start = 1'b1; file_size = 32'd8272;
        @(negedge clk32);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk32);
            if (rd_req && rd_addr == BASE + 25'd5) found = 1;
        end
        check("abort reached_wait", 32'(found), 32'd1);
        repeat (2) @(negedge clk32);
        check("abort req_held", {7'd0, rd_req, rd_addr}, {7'd0, 1'b1, BASE + 25'd5});
        reset = 1'b1;
        @(negedge clk32);
        reset = 1'b0;
        check("abort rd_req", 32'(rd_req), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort file_type", 32'(file_type), 32'd0);
        force_req++;
        bz = 0; dn = 0;
        repeat (6) begin
            @(negedge clk32);
            if (busy || rd_req) bz++;
            if (done) dn++;
        end
        check("abort late_ack busy", 32'(bz), 32'd0);
        check("abort no_done", 32'(dn), 32'd0);
        hold_at = 1 << 30;
        run_one("after_abort", 32'd8272, mk("C64 CARTRIDGE   "), 2, 3'd3, 16'h0000, 1'b0);

        // randomized headers and sizes against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [0:15][7:0] b;
            logic [31:0] sz;
            logic [2:0]  et;
            int d;
            case ($urandom_range(0, 4))
                0: b = mk("C64 CARTRIDGE   ");
                1: b = mk("C64-TAPE-RAW");
                2: b = mk("C64S");
                3: b = mk("C64 tape");
                default: for (int j = 0; j < 16; j++) b[j] = 8'($urandom);
            endcase
            for (int j = 0; j < 16; j++)
                if (b[j] == 8'h00) b[j] = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                int p = $urandom_range(0, 15);
                b[p] = b[p] ^ 8'h20;
            end
            case ($urandom_range(0, 3))
                0: sz = 32'($urandom_range(0, 20));
                1: sz = 32'($urandom_range(12, 16));
                2: sz = 32'($urandom) | 32'h8000_0000;
                default: sz = 32'($urandom_range(17, 70000));
            endcase
            d  = $urandom_range(0, 3);
            et = model_type(sz, b);
            run_one($sformatf("rnd%0d", i), sz, b, d, et,
                    (et == 3'd1) ? {b[1], b[0]} : 16'h0000, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
